exc_ctrl: RTL and testbench



---
 rtl/exc_ctrl.sv | 186 ++++++++++++++++++
 tb/tb_exc_ctrl.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/exc_ctrl.sv
// Exception / ERET sequencer at the MEM stage: snapshots the trigger context,
// drives the single CP0 write port one register per cycle, then flushes and redirects fetch.
module exc_ctrl #(
    parameter logic [31:0] VEC_OFFSET = 32'h0000_0180
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_valid,
    input  logic [31:0] mem_pc,
    input  logic        mem_in_delay,
    input  logic        mem_is_syscall,
    input  logic        mem_is_eret,
    input  logic [31:0] cp0_status,
    input  logic [31:0] cp0_cause,
    input  logic [31:0] cp0_epc,
    input  logic [31:0] cp0_ebase,
    output logic        cp0_we,
    output logic [5:0]  cp0_waddr,
    output logic [31:0] cp0_wdata,
    output logic        flush,
    output logic        stall_req,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc
);

    typedef enum logic [2:0] {
        IDLE,
        WR_EPC,
        WR_CAUSE,
        WR_STATUS,
        REDIRECT
    } state_e;

    localparam logic [5:0] ADDR_STATUS = 6'd12;
    localparam logic [5:0] ADDR_CAUSE  = 6'd13;
    localparam logic [5:0] ADDR_EPC    = 6'd14;
    localparam logic [4:0] CODE_INT    = 5'h00;
    localparam logic [4:0] CODE_SYS    = 5'h08;

    state_e      state_q, state_d;

    logic [31:0] snapPc_q, snapPc_d;
    logic        snapBd_q, snapBd_d;
    logic [31:0] snapStatus_q, snapStatus_d;
    logic [31:0] snapCause_q, snapCause_d;
    logic [31:0] snapEpc_q, snapEpc_d;
    logic [31:0] snapEbase_q, snapEbase_d;
    logic [4:0]  snapCode_q, snapCode_d;
    logic        snapEret_q, snapEret_d;

    logic        cp0We_q, cp0We_d;
    logic [5:0]  cp0Waddr_q, cp0Waddr_d;
    logic [31:0] cp0Wdata_q, cp0Wdata_d;
    logic        flush_q, flush_d;
    logic        stallReq_q, stallReq_d;
    logic        redirectValid_q, redirectValid_d;
    logic [31:0] redirectPc_q, redirectPc_d;

    logic        intPending;

    assign intPending = cp0_status[0] & ~cp0_status[1] &
                        (|(cp0_cause[15:8] & cp0_status[15:8]));

    // Outputs are computed from the state being entered and the snapshot being
    // loaded on the same edge, so each output cycle lines up with its state.
    always_comb begin
        state_d         = state_q;
        snapPc_d        = snapPc_q;
        snapBd_d        = snapBd_q;
        snapStatus_d    = snapStatus_q;
        snapCause_d     = snapCause_q;
        snapEpc_d       = snapEpc_q;
        snapEbase_d     = snapEbase_q;
        snapCode_d      = snapCode_q;
        snapEret_d      = snapEret_q;
        cp0We_d         = 1'b0;
        cp0Waddr_d      = 6'd0;
        cp0Wdata_d      = 32'd0;
        flush_d         = 1'b0;
        stallReq_d      = 1'b0;
        redirectValid_d = 1'b0;
        redirectPc_d    = 32'd0;

        case (state_q)
            IDLE: begin
                if (mem_valid && (intPending || mem_is_syscall || mem_is_eret)) begin
                    snapPc_d     = mem_pc;
                    snapBd_d     = mem_in_delay;
                    snapStatus_d = cp0_status;
                    snapCause_d  = cp0_cause;
                    snapEpc_d    = cp0_epc;
                    snapEbase_d  = cp0_ebase;
                    if (intPending || mem_is_syscall) begin
                        snapCode_d = intPending ? CODE_INT : CODE_SYS;
                        snapEret_d = 1'b0;
                        state_d    = WR_EPC;
                    end else begin
                        snapCode_d = CODE_INT;
                        snapEret_d = 1'b1;
                        state_d    = WR_STATUS;
                    end
                end
            end
            WR_EPC:    state_d = WR_CAUSE;
            WR_CAUSE:  state_d = WR_STATUS;
            WR_STATUS: state_d = REDIRECT;
            REDIRECT:  state_d = IDLE;
            default:   state_d = IDLE;
        endcase

        case (state_d)
            WR_EPC: begin
                cp0We_d    = 1'b1;
                cp0Waddr_d = ADDR_EPC;
                cp0Wdata_d = snapBd_d ? (snapPc_d - 32'd4) : snapPc_d;
            end
            WR_CAUSE: begin
                cp0We_d    = 1'b1;
                cp0Waddr_d = ADDR_CAUSE;
                cp0Wdata_d = {snapBd_d, snapCause_d[30:7], snapCode_d, 2'b00};
            end
            WR_STATUS: begin
                cp0We_d    = 1'b1;
                cp0Waddr_d = ADDR_STATUS;
                cp0Wdata_d = snapEret_d ? (snapStatus_d & ~32'h2) : (snapStatus_d | 32'h2);
            end
            REDIRECT: begin
                redirectValid_d = 1'b1;
                redirectPc_d    = snapEret_d ? snapEpc_d : (snapEbase_d + VEC_OFFSET);
            end
            default: ;
        endcase

        if (state_d != IDLE) begin
            flush_d    = 1'b1;
            stallReq_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= IDLE;
            snapPc_q        <= 32'd0;
            snapBd_q        <= 1'b0;
            snapStatus_q    <= 32'd0;
            snapCause_q     <= 32'd0;
            snapEpc_q       <= 32'd0;
            snapEbase_q     <= 32'd0;
            snapCode_q      <= 5'd0;
            snapEret_q      <= 1'b0;
            cp0We_q         <= 1'b0;
            cp0Waddr_q      <= 6'd0;
            cp0Wdata_q      <= 32'd0;
            flush_q         <= 1'b0;
            stallReq_q      <= 1'b0;
            redirectValid_q <= 1'b0;
            redirectPc_q    <= 32'd0;
        end else begin
            state_q         <= state_d;
            snapPc_q        <= snapPc_d;
            snapBd_q        <= snapBd_d;
            snapStatus_q    <= snapStatus_d;
            snapCause_q     <= snapCause_d;
            snapEpc_q       <= snapEpc_d;
            snapEbase_q     <= snapEbase_d;
            snapCode_q      <= snapCode_d;
            snapEret_q      <= snapEret_d;
            cp0We_q         <= cp0We_d;
            cp0Waddr_q      <= cp0Waddr_d;
            cp0Wdata_q      <= cp0Wdata_d;
            flush_q         <= flush_d;
            stallReq_q      <= stallReq_d;
            redirectValid_q <= redirectValid_d;
            redirectPc_q    <= redirectPc_d;
        end
    end

    assign cp0_we         = cp0We_q;
    assign cp0_waddr      = cp0Waddr_q;
    assign cp0_wdata      = cp0Wdata_q;
    assign flush          = flush_q;
    assign stall_req      = stallReq_q;
    assign redirect_valid = redirectValid_q;
    assign redirect_pc    = redirectPc_q;

endmodule

// File: tb/tb_exc_ctrl.sv
// Directed bench for exc_ctrl: a per-cycle vector table of inputs and expected
// registered outputs, followed by a hand-written latency/pulse-count sequence.
module tb_exc_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_valid;
    logic [31:0] mem_pc;
    logic        mem_in_delay;
    logic        mem_is_syscall;
    logic        mem_is_eret;
    logic [31:0] cp0_status;
    logic [31:0] cp0_cause;
    logic [31:0] cp0_epc;
    logic [31:0] cp0_ebase;
    logic        cp0_we;
    logic [5:0]  cp0_waddr;
    logic [31:0] cp0_wdata;
    logic        flush;
    logic        stall_req;
    logic        redirect_valid;
    logic [31:0] redirect_pc;

    always #5 clk = ~clk;

    exc_ctrl dut (
        .clk            (clk),
        .rst            (rst),
        .mem_valid      (mem_valid),
        .mem_pc         (mem_pc),
        .mem_in_delay   (mem_in_delay),
        .mem_is_syscall (mem_is_syscall),
        .mem_is_eret    (mem_is_eret),
        .cp0_status     (cp0_status),
        .cp0_cause      (cp0_cause),
        .cp0_epc        (cp0_epc),
        .cp0_ebase      (cp0_ebase),
        .cp0_we         (cp0_we),
        .cp0_waddr      (cp0_waddr),
        .cp0_wdata      (cp0_wdata),
        .flush          (flush),
        .stall_req      (stall_req),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc)
    );

    // Inputs held for one cycle, and the outputs expected right after the edge
    // that samples them; full=1 also demands zero/unused fields be exact.
    typedef struct {
        string       name;
        logic        rst;
        logic        valid;
        logic [31:0] pc;
        logic        bd;
        logic        sys;
        logic        eret;
        logic [31:0] status;
        logic [31:0] cause;
        logic [31:0] epc;
        logic [31:0] ebase;
        logic        full;
        logic        expWe;
        logic [5:0]  expWaddr;
        logic [31:0] expWdata;
        logic        expFlush;
        logic        expRv;
        logic [31:0] expRpc;
    } vec_t;

    vec_t vecs[$];
    int   errors = 0;
    int   checks = 0;

    function automatic vec_t mkIn(string n, logic r, logic v, logic [31:0] pc, logic bd,
                                  logic sys, logic er, logic [31:0] st, logic [31:0] ca,
                                  logic [31:0] ep, logic [31:0] eb);
        vec_t x;
        x.name = n; x.rst = r; x.valid = v; x.pc = pc; x.bd = bd; x.sys = sys;
        x.eret = er; x.status = st; x.cause = ca; x.epc = ep; x.ebase = eb;
        x.full = 1'b1; x.expWe = 1'b0; x.expWaddr = 6'd0; x.expWdata = 32'd0;
        x.expFlush = 1'b0; x.expRv = 1'b0; x.expRpc = 32'd0;
        return x;
    endfunction

    function automatic vec_t quiet(string n);
        return mkIn(n, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0, 32'd0);
    endfunction

    function automatic vec_t expWr(vec_t x, logic [5:0] a, logic [31:0] d);
        vec_t y = x;
        y.full = 1'b0; y.expWe = 1'b1; y.expWaddr = a; y.expWdata = d; y.expFlush = 1'b1;
        return y;
    endfunction

    function automatic vec_t expRedir(vec_t x, logic [31:0] p);
        vec_t y = x;
        y.full = 1'b0; y.expRv = 1'b1; y.expRpc = p; y.expFlush = 1'b1;
        return y;
    endfunction

    task automatic applyStimulus(input vec_t x);
        rst            = x.rst;
        mem_valid      = x.valid;
        mem_pc         = x.pc;
        mem_in_delay   = x.bd;
        mem_is_syscall = x.sys;
        mem_is_eret    = x.eret;
        cp0_status     = x.status;
        cp0_cause      = x.cause;
        cp0_epc        = x.epc;
        cp0_ebase      = x.ebase;
    endtask

    task automatic checkOutput(input vec_t x);
        logic ok;
        checks++;
        ok = (cp0_we === x.expWe) && (flush === x.expFlush) &&
             (stall_req === x.expFlush) && (redirect_valid === x.expRv);
        if (x.expWe || x.full)
            ok = ok && (cp0_waddr === x.expWaddr) && (cp0_wdata === x.expWdata);
        if (x.expRv || x.full)
            ok = ok && (redirect_pc === x.expRpc);
        if (!ok) begin
            errors++;
            $display("[TB] FAIL %s: got we=%b addr=%0d data=%h flush=%b stall=%b rv=%b rpc=%h, want we=%b addr=%0d data=%h flush=%b rv=%b rpc=%h",
                     x.name, cp0_we, cp0_waddr, cp0_wdata, flush, stall_req, redirect_valid,
                     redirect_pc, x.expWe, x.expWaddr, x.expWdata, x.expFlush, x.expRv, x.expRpc);
        end
    endtask

    task automatic checkVal(input string n, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("[TB] FAIL %s: got %h, want %h", n, got, want);
        end
    endtask

    initial begin
        vec_t v;
        int   weCount;
        int   lat;
        logic found;

        // Reset, then idle.
        v = quiet("reset0"); v.rst = 1'b1; vecs.push_back(v);
        v = quiet("reset1"); v.rst = 1'b1; vecs.push_back(v);
        for (int i = 0; i < 10; i++) vecs.push_back(quiet($sformatf("idle%0d", i)));

        // SYSCALL, no delay slot; live CP0 values change after detect.
        vecs.push_back(expWr(mkIn("sys_epc", 0, 1, 32'h0000_0400, 0, 1, 0, 32'h0000_FF01, 32'h0, 32'h0, 32'h8000_0000), 6'd14, 32'h0000_0400));
        vecs.push_back(expWr(mkIn("sys_cause", 0, 0, 32'h0, 0, 0, 0, 32'h0, 32'h0000_FF00, 32'h0, 32'hDEAD_0000), 6'd13, 32'h0000_0020));
        vecs.push_back(expWr(mkIn("sys_status", 0, 0, 32'h0, 0, 0, 0, 32'h0, 32'h0, 32'h0, 32'hDEAD_0000), 6'd12, 32'h0000_FF03));
        vecs.push_back(expRedir(quiet("sys_redir"), 32'h8000_0180));
        vecs.push_back(mkIn("sys_drop_in_redir", 0, 1, 32'h0000_0700, 0, 1, 0, 32'h0, 32'h0, 32'h0, 32'h0));

        // Back-to-back: interrupt in delay slot (SYSCALL also set, interrupt wins).
        vecs.push_back(expWr(mkIn("int_epc", 0, 1, 32'h0000_1000, 1, 1, 0, 32'h0000_0401, 32'h0000_047F, 32'h0, 32'h8000_0000), 6'd14, 32'h0000_0FFC));
        vecs.push_back(expWr(quiet("int_cause"), 6'd13, 32'h8000_0400));
        vecs.push_back(expWr(quiet("int_status"), 6'd12, 32'h0000_0403));
        vecs.push_back(expRedir(quiet("int_redir"), 32'h8000_0180));
        vecs.push_back(quiet("int_idle"));

        // Blocked cases, then masked interrupt with ERET.
        vecs.push_back(mkIn("invalid_sys", 0, 0, 32'h0, 0, 1, 0, 32'h0, 32'h0, 32'h0, 32'h0));
        vecs.push_back(mkIn("int_ie0", 0, 1, 32'h0, 0, 0, 0, 32'h0000_0400, 32'h0000_0400, 32'h0, 32'h0));
        vecs.push_back(expWr(mkIn("eret_status", 0, 1, 32'h0000_3000, 0, 0, 1, 32'h0000_0403, 32'h0000_0400, 32'h0000_2340, 32'h8000_0000), 6'd12, 32'h0000_0401));
        vecs.push_back(expRedir(mkIn("eret_redir", 0, 0, 32'h0, 0, 0, 0, 32'h0, 32'h0, 32'h0000_9999, 32'h0), 32'h0000_2340));
        vecs.push_back(quiet("eret_idle"));

        // Busy drop at pc=0 with ebase wrap.
        vecs.push_back(expWr(mkIn("wrap_epc", 0, 1, 32'h0, 0, 1, 0, 32'h0, 32'h0, 32'h0, 32'hFFFF_FF00), 6'd14, 32'h0));
        vecs.push_back(expWr(quiet("wrap_cause"), 6'd13, 32'h0000_0020));
        vecs.push_back(expWr(mkIn("wrap_status_drop", 0, 1, 32'h0000_5555, 0, 1, 0, 32'h0, 32'h0, 32'h0, 32'h0), 6'd12, 32'h0000_0002));
        vecs.push_back(expRedir(quiet("wrap_redir"), 32'h0000_0080));
        vecs.push_back(quiet("wrap_idle0"));
        vecs.push_back(quiet("wrap_idle1"));

        // Same with bd=1: pc-4 wraps.
        vecs.push_back(expWr(mkIn("bdwrap_epc", 0, 1, 32'h0, 1, 1, 0, 32'h0, 32'h0, 32'h0, 32'h0), 6'd14, 32'hFFFF_FFFC));
        vecs.push_back(expWr(quiet("bdwrap_cause"), 6'd13, 32'h8000_0020));
        vecs.push_back(expWr(quiet("bdwrap_status"), 6'd12, 32'h0000_0002));
        vecs.push_back(expRedir(quiet("bdwrap_redir"), 32'h0000_0180));
        vecs.push_back(quiet("bdwrap_idle"));

        // Reset during WR_CAUSE abandons the rest of the sequence.
        vecs.push_back(expWr(mkIn("rst_epc", 0, 1, 32'h0000_0400, 0, 1, 0, 32'h0000_0001, 32'h0, 32'h0, 32'h8000_0000), 6'd14, 32'h0000_0400));
        vecs.push_back(expWr(quiet("rst_cause"), 6'd13, 32'h0000_0020));
        v = quiet("rst_mid"); v.rst = 1'b1; vecs.push_back(v);
        vecs.push_back(quiet("rst_after0"));
        vecs.push_back(quiet("rst_after1"));

        foreach (vecs[i]) begin
            applyStimulus(vecs[i]);
            @(posedge clk);
            #1;
            checkOutput(vecs[i]);
        end

        // Hand sequence: three single-cycle writes, redirect four cycles after
        // detect, target taken from the snapshot rather than the live EBase.
        applyStimulus(mkIn("seq", 0, 1, 32'h0000_0008, 0, 1, 0, 32'h0000_0001, 32'h0, 32'h0, 32'h1234_0000));
        @(posedge clk);
        #1;
        applyStimulus(mkIn("seq", 0, 0, 32'h0, 0, 0, 0, 32'h0, 32'h0, 32'h0, 32'h0));
        weCount = 0;
        lat     = 1;
        found   = 1'b0;
        while (!found && lat <= 10) begin
            if (cp0_we) weCount++;
            if (redirect_valid) begin
                found = 1'b1;
            end else begin
                @(posedge clk);
                #1;
                lat++;
            end
        end
        checkVal("seq_redirect_seen", {31'd0, found}, 32'd1);
        checkVal("seq_latency", lat, 32'd4);
        checkVal("seq_we_pulses", weCount, 32'd3);
        checkVal("seq_redirect_pc", redirect_pc, 32'h1234_0180);
        @(posedge clk);
        #1;
        checkVal("seq_back_idle", {30'd0, flush, stall_req}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
